// File: rtl/pll_lock_rst_ctrl.sv
// PLL supervisor: per-channel reset pulse, debounced lock qualification, timeout retry, domain reset release.
// Optional build macro PLL_RELOCK_CNT_EN adds saturating per-channel lost-lock counters on relock_cnt.
module pll_lock_rst_ctrl #(
  parameter int N_PLL        = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int SEQ_RELEASE  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PLL-1:0]   pll_lock,
  input  logic [N_PLL-1:0]   pll_rst_req,
  input  logic               timeout_clr,
  output logic [N_PLL-1:0]   pll_rst,
  output logic [N_PLL-1:0]   rst_out_n,
  output logic               ready_all,
  output logic [N_PLL-1:0]   timeout,
  output logic [8*N_PLL-1:0] relock_cnt
);
  localparam int RW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
  localparam int SW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Per-channel FSM state and counters, kept together so g_ch[i].q is the observable debug view.
  typedef struct packed {
    logic [1:0]    state;
    logic [RW-1:0] rst_cnt;
    logic [SW-1:0] stb_cnt;
    logic [TW-1:0] tmo_cnt;
  } ch_t;

  logic [N_PLL-1:0] lock_m;
  logic [N_PLL-1:0] lock_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_m <= '0;
      lock_s <= '0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  for (genvar i = 0; i < N_PLL; i++) begin : g_ch
    ch_t  q;
    ch_t  d;
    logic tmo_hit;
    logic gate;

    // Channel 0 is never gated; higher channels follow their predecessor when sequencing.
    if (i == 0 || SEQ_RELEASE == 0) begin : g_ungated
      assign gate = 1'b1;
    end else begin : g_gated
      assign gate = rst_out_n[i-1];
    end

    always_comb begin
      d       = q;
      tmo_hit = 1'b0;
      if (pll_rst_req[i]) begin
        d       = '0;
        d.state = ST_RST;
      end else begin
        case (q.state)
          ST_RST: begin
            if (q.rst_cnt == RST_LAST) begin
              d       = '0;
              d.state = ST_WAIT;
            end else begin
              d.rst_cnt = q.rst_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (lock_s[i] && q.stb_cnt == STB_LAST) begin
              d       = '0;
              d.state = ST_RUN;
            end else if (q.tmo_cnt == TMO_LAST) begin
              d       = '0;
              d.state = ST_RST;
              tmo_hit = 1'b1;
            end else begin
              d.tmo_cnt = q.tmo_cnt + 1'b1;
              d.stb_cnt = lock_s[i] ? q.stb_cnt + 1'b1 : '0;
            end
          end
          ST_RUN: begin
            if (!lock_s[i]) begin
              d       = '0;
              d.state = ST_RST;
            end
          end
          default: begin
            d       = '0;
            d.state = ST_RST;
          end
        endcase
      end
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q            <= '0;
        pll_rst[i]   <= 1'b1;
        rst_out_n[i] <= 1'b0;
        timeout[i]   <= 1'b0;
      end else begin
        q            <= d;
        pll_rst[i]   <= (d.state == ST_RST);
        rst_out_n[i] <= (d.state == ST_RUN) && gate;
        timeout[i]   <= tmo_hit | (timeout[i] & ~timeout_clr);
      end
    end

`ifdef PLL_RELOCK_CNT_EN
    logic lost;
    assign lost = (q.state == ST_RUN) && !lock_s[i] && !pll_rst_req[i];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        relock_cnt[8*i +: 8] <= 8'h00;
      end else if (lost && relock_cnt[8*i +: 8] != 8'hFF) begin
        relock_cnt[8*i +: 8] <= relock_cnt[8*i +: 8] + 8'd1;
      end
    end
`else
    assign relock_cnt[8*i +: 8] = 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_all <= 1'b0;
    end else begin
      ready_all <= &rst_out_n;
    end
  end

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// Bench for pll_lock_rst_ctrl: vector table, directed timing sequences and random stimulus
// checked every cycle against a timestamp/history reference model.
`timescale 1ns/1ps
module tb_pll_lock_rst_ctrl;
  localparam int RSTC = 4;
  localparam int STB  = 8;
  localparam int TMO  = 64;
`ifdef PLL_RELOCK_CNT_EN
  localparam int RELOCK_ONE = 1;
`else
  localparam int RELOCK_ONE = 0;
`endif

  localparam int RESETTING = 0;
  localparam int SEARCHING = 1;
  localparam int LOCKED    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pll_lock = 2'b00;
  logic [1:0]  pll_rst_req = 2'b00;
  logic        timeout_clr = 1'b0;
  logic [1:0]  pll_rst, rst_out_n, timeout;
  logic        ready_all;
  logic [15:0] relock_cnt;
  logic [1:0]  s_pll_rst, s_rst_out_n, s_timeout;
  logic        s_ready_all;
  logic [15:0] s_relock_cnt;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pll_lock_rst_ctrl #(.N_PLL(2), .RST_CYCLES(RSTC), .LOCK_STABLE(STB),
                      .LOCK_TIMEOUT(TMO), .SEQ_RELEASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst_req(pll_rst_req),
    .timeout_clr(timeout_clr), .pll_rst(pll_rst), .rst_out_n(rst_out_n),
    .ready_all(ready_all), .timeout(timeout), .relock_cnt(relock_cnt));

  pll_lock_rst_ctrl #(.N_PLL(2), .RST_CYCLES(RSTC), .LOCK_STABLE(STB),
                      .LOCK_TIMEOUT(TMO), .SEQ_RELEASE(1)) dut_seq (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst_req(pll_rst_req),
    .timeout_clr(timeout_clr), .pll_rst(s_pll_rst), .rst_out_n(s_rst_out_n),
    .ready_all(s_ready_all), .timeout(s_timeout), .relock_cnt(s_relock_cnt));

  initial begin
    #1ms;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each channel is described by its mode and the edge at which it entered that mode;
  // lock qualification looks back over a window of synchronised samples.
  int         edge_n = 0;
  int         rst_edge = 0;
  int         mode [2];
  int         entered [2];
  int         m_relock [2];
  bit         lkq [2][$];
  logic [1:0] m_pll_rst = 2'b11, m_rst_out = 2'b00, m_rst_seq = 2'b00, m_tmo = 2'b00;
  logic       m_ready = 1'b0, m_ready_seq = 1'b0;

  // Synchronised lock seen by the channel at edge m: the raw sample two edges earlier,
  // or 0 while the synchroniser still holds its reset value.
  function automatic bit ls_at(int ch, int m);
    int idx;
    if (m - 2 <= rst_edge) return 1'b0;
    idx = m - 2 - rst_edge - 1;
    if (idx >= lkq[ch].size()) return 1'b0;
    return lkq[ch][idx];
  endfunction

  function automatic bit window_ok(int ch, int m);
    for (int k = 0; k < STB; k++)
      if (!ls_at(ch, m - k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [1:0] prev_out, prev_seq;
    int age;
    bit tset;
    if (!rst_n) begin
      rst_edge = edge_n;
      for (int c = 0; c < 2; c++) begin
        mode[c] = RESETTING; entered[c] = edge_n; m_relock[c] = 0;
        lkq[c].delete();
      end
      m_pll_rst = 2'b11; m_rst_out = 2'b00; m_rst_seq = 2'b00; m_tmo = 2'b00;
      m_ready = 1'b0; m_ready_seq = 1'b0;
    end else begin
      prev_out = m_rst_out;
      prev_seq = m_rst_seq;
      for (int c = 0; c < 2; c++) begin
        age  = edge_n - entered[c];
        tset = 1'b0;
        if (pll_rst_req[c]) begin
          mode[c] = RESETTING; entered[c] = edge_n;
        end else if (mode[c] == RESETTING) begin
          if (age == RSTC) begin mode[c] = SEARCHING; entered[c] = edge_n; end
        end else if (mode[c] == SEARCHING) begin
          if (age >= STB && window_ok(c, edge_n)) begin
            mode[c] = LOCKED; entered[c] = edge_n;
          end else if (age == TMO) begin
            mode[c] = RESETTING; entered[c] = edge_n; tset = 1'b1;
          end
        end else if (!ls_at(c, edge_n)) begin
          mode[c] = RESETTING; entered[c] = edge_n;
          if (m_relock[c] < 255) m_relock[c]++;
        end
        m_tmo[c] = tset ? 1'b1 : (timeout_clr ? 1'b0 : m_tmo[c]);
        lkq[c].push_back(pll_lock[c]);
        m_pll_rst[c] = (mode[c] == RESETTING);
        m_rst_out[c] = (mode[c] == LOCKED);
      end
      m_rst_seq[0] = (mode[0] == LOCKED);
      m_rst_seq[1] = (mode[1] == LOCKED) && prev_seq[0];
      m_ready      = &prev_out;
      m_ready_seq  = &prev_seq;
    end
    edge_n++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] exp_rl;
`ifdef PLL_RELOCK_CNT_EN
    exp_rl = {8'(m_relock[1]), 8'(m_relock[0])};
`else
    exp_rl = 16'h0000;
`endif
    check("mdl_pll_rst",     32'(pll_rst),      32'(m_pll_rst));
    check("mdl_rst_out_n",   32'(rst_out_n),    32'(m_rst_out));
    check("mdl_ready_all",   32'(ready_all),    32'(m_ready));
    check("mdl_timeout",     32'(timeout),      32'(m_tmo));
    check("mdl_relock",      32'(relock_cnt),   32'(exp_rl));
    check("mdl_seq_pll_rst", 32'(s_pll_rst),    32'(m_pll_rst));
    check("mdl_seq_rst_out", 32'(s_rst_out_n),  32'(m_rst_seq));
    check("mdl_seq_ready",   32'(s_ready_all),  32'(m_ready_seq));
    check("mdl_seq_timeout", 32'(s_timeout),    32'(m_tmo));
    check("mdl_seq_relock",  32'(s_relock_cnt), 32'(exp_rl));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         cyc;
    logic [1:0] lock;
    logic [1:0] req;
    logic       clr;
    logic [1:0] e_pll_rst;
    logic [1:0] e_rst_out;
    logic [1:0] e_tmo;
    logic       e_ready;
  } vec_t;

  vec_t vt [14];
  int   n;
  int   since;

  initial begin
    vt[0]  = '{3,  2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
    vt[1]  = '{1,  2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    vt[2]  = '{9,  2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    vt[3]  = '{1,  2'b11, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0};
    vt[4]  = '{1,  2'b11, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1};
    vt[5]  = '{2,  2'b01, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1};
    vt[6]  = '{1,  2'b01, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00, 1'b1};
    vt[7]  = '{1,  2'b01, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0};
    vt[8]  = '{1,  2'b01, 2'b01, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
    vt[9]  = '{4,  2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    vt[10] = '{61, 2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
    vt[11] = '{1,  2'b01, 2'b00, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0};
    vt[12] = '{1,  2'b01, 2'b00, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0};
    vt[13] = '{3,  2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};

    // Reset values
    do_reset();
    check("rst_pll_rst",   32'(pll_rst),    32'h3);
    check("rst_rst_out_n", 32'(rst_out_n),  32'h0);
    check("rst_ready_all", 32'(ready_all),  32'h0);
    check("rst_timeout",   32'(timeout),    32'h0);
    check("rst_relock",    32'(relock_cnt), 32'h0);

    // Vector table, starting from reset release
    for (int v = 0; v < 14; v++) begin
      pll_lock = vt[v].lock; pll_rst_req = vt[v].req; timeout_clr = vt[v].clr;
      repeat (vt[v].cyc) tick();
      check($sformatf("vec%0d_pll_rst", v), 32'(pll_rst),   32'(vt[v].e_pll_rst));
      check($sformatf("vec%0d_rst_out", v), 32'(rst_out_n), 32'(vt[v].e_rst_out));
      check($sformatf("vec%0d_timeout", v), 32'(timeout),   32'(vt[v].e_tmo));
      check($sformatf("vec%0d_ready", v),   32'(ready_all), 32'(vt[v].e_ready));
    end
    pll_rst_req = 2'b00; timeout_clr = 1'b0;

    // Clean lock
    pll_lock = 2'b00; do_reset();
    n = 0; do begin tick(); n++; end while (pll_rst[0] && n < 20);
    check("clean_rst_pulse", n, 4);
    repeat (5) tick();
    pll_lock[0] = 1'b1;
    n = 0; do begin tick(); n++; end while (!rst_out_n[0] && n < 40);
    check("clean_lock_latency", n, 10);
    repeat (3) begin tick(); check("clean_ready_low", 32'(ready_all), 0); end
    pll_lock[1] = 1'b1;
    n = 0; do begin tick(); n++; end while (!rst_out_n[1] && n < 40);
    check("clean_lock1_latency", n, 10);
    check("clean_ready_lag", 32'(ready_all), 0);
    tick();
    check("clean_ready_high", 32'(ready_all), 1);

    // Glitch restarts the stable window
    pll_lock = 2'b00; do_reset();
    repeat (4) tick();
    pll_lock[0] = 1'b1; repeat (5) tick();
    pll_lock[0] = 1'b0; tick();
    pll_lock[0] = 1'b1;
    n = 0; do begin tick(); n++; end while (!rst_out_n[0] && n < 40);
    check("glitch_latency", n, 10);

    // Loss of lock in RUN for 3 cycles
    pll_lock[0] = 1'b0;
    n = 0; do begin tick(); n++; end while (rst_out_n[0] && n < 20);
    check("loss_fall", n, 3);
    check("loss_pll_rst_rise", 32'(pll_rst[0]), 1);
    pll_lock[0] = 1'b1;
    n = 0; do begin tick(); n++; end while (pll_rst[0] && n < 20);
    check("loss_rst_pulse", n, 4);
    n = 0; do begin tick(); n++; end while (!rst_out_n[0] && n < 40);
    check("loss_requal", n, 8);
    check("loss_relock_ch0", 32'(relock_cnt[7:0]), RELOCK_ONE);

    // Timeout and retry period
    pll_lock = 2'b01; do_reset();
    n = 0; do begin tick(); n++; end while (!timeout[1] && n < 200);
    check("tmo_first", n, 68);
    check("tmo_pll_rst", 32'(pll_rst[1]), 1);
    n = 0; do begin tick(); n++; end while (pll_rst[1] && n < 20);
    check("tmo_rst_pulse", n, 4);
    since = n;
    timeout_clr = 1'b1; tick(); timeout_clr = 1'b0; since++;
    check("tmo_clr", 32'(timeout[1]), 0);
    n = 0; do begin tick(); n++; end while (!timeout[1] && n < 200);
    check("tmo_period", since + n, 68);

    // Sequenced release on the SEQ_RELEASE=1 instance
    pll_lock = 2'b10; do_reset();
    repeat (20) tick();
    pll_lock = 2'b11;
    n = 0;
    do begin
      tick(); n++;
      check("seq_hold", 32'(s_rst_out_n[1]), 0);
    end while (!s_rst_out_n[0] && n < 40);
    check("seq_ch0_latency", n, 10);
    tick();
    check("seq_ch1_rise", 32'(s_rst_out_n[1]), 1);
    pll_lock[0] = 1'b0;
    n = 0; do begin tick(); n++; end while (s_rst_out_n[0] && n < 20);
    check("seq_ch1_still_up", 32'(s_rst_out_n[1]), 1);
    tick();
    check("seq_ch1_fall", 32'(s_rst_out_n[1]), 0);
    check("seq_ch1_fsm_run", 32'(s_pll_rst[1]), 0);
    pll_lock[0] = 1'b1;
    n = 0; do begin tick(); n++; end while (!s_rst_out_n[1] && n < 60);
    check("seq_requal", 32'(s_rst_out_n[1]), 1);

    // Mid-operation reset with a soft request pending
    pll_rst_req = 2'b01; rst_n = 1'b0;
    tick();
    check("mid_pll_rst",   32'(pll_rst),     32'h3);
    check("mid_rst_out_n", 32'(rst_out_n),   32'h0);
    check("mid_ready",     32'(ready_all),   32'h0);
    check("mid_seq_out",   32'(s_rst_out_n), 32'h0);
    check("mid_relock",    32'(relock_cnt),  32'h0);
    rst_n = 1'b1; pll_rst_req = 2'b00;
    n = 0; do begin tick(); n++; end while (pll_rst != 2'b00 && n < 20);
    check("mid_fresh_pulse", n, 4);

    // Random stimulus against the model
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 39) == 0) pll_lock[c] = ~pll_lock[c];
      pll_rst_req = 2'b00;
      if ($urandom_range(0, 119) == 0) pll_rst_req = 2'($urandom_range(1, 3));
      timeout_clr = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_rst_ctrl.md
Name: pll_lock_rst_ctrl

Overview:
- Supervises N_PLL GTP_PLL_E3 instances from one free-running reference clock (the 50 MHz board clock that feeds the PLLs).
- Per PLL: drives the PLL reset pulse, qualifies LOCK with a debounce window, and retries automatically on lock timeout.
- Releases a per-domain reset once lock is qualified, optionally in channel order, and pulls it back on loss of lock.
- Sits between the PLL wrappers and the HDMI/HSST datapath reset trees.

Parameters:
- N_PLL, 2, number of supervised PLLs (1..8).
- RST_CYCLES, 16, width of the pll_rst pulse in clk cycles (>=1).
- LOCK_STABLE, 1024, consecutive synchronised-lock cycles required to qualify lock (>=1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT before retry (> LOCK_STABLE).
- SEQ_RELEASE, 0, 1 = rst_out_n[i] gated by rst_out_n[i-1].

Ports:
- clk  in  1  free-running reference clock.
- rst_n  in  1  synchronous active-low reset.
- pll_lock  in  N_PLL  raw PLL LOCK outputs, asynchronous to clk.
- pll_rst_req  in  N_PLL  per-channel soft restart request, level, clk domain.
- timeout_clr  in  1  clears all sticky timeout flags.
- pll_rst  out  N_PLL  PLL RST drive, active-high.
- rst_out_n  out  N_PLL  downstream domain reset, active-low.
- ready_all  out  1  all rst_out_n bits high.
- timeout  out  N_PLL  sticky lock-timeout flag.
- relock_cnt  out  8*N_PLL  per-channel lost-lock count; see Optional Feature.

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - pll_rst = all ones; rst_out_n = 0; ready_all = 0; timeout = 0; relock_cnt = 0.
  - All FSMs in RST with counters at 0.
- Synchronisation: 2-flop synchroniser per pll_lock bit. lock_s lags pll_lock by 2 cycles.
- Counter widths are $clog2 of the respective parameter. Counters never wrap; each is cleared on every state entry.
- Per-channel FSM, all outputs registered:
  - RST:
    - pll_rst[i]=1, rst_out_n[i]=0.
    - Counts RST_CYCLES cycles, then moves to WAIT.
  - WAIT:
    - pll_rst[i]=0.
    - tmo_cnt increments every cycle. stb_cnt increments while lock_s=1 and is zeroed when lock_s=0.
    - When lock_s=1 and stb_cnt=LOCK_STABLE-1, go to RUN.
    - Otherwise, when tmo_cnt=LOCK_TIMEOUT-1, go to RST and set timeout[i].
    - If both conditions hold in the same cycle, RUN wins.
  - RUN:
    - rst_out_n[i]=1, or with SEQ_RELEASE=1: 1 only when rst_out_n[i-1]=1 (channel 0 ungated).
    - On lock_s=0, go to RST. rst_out_n[i] falls on that same edge.
- pll_rst_req[i]=1 forces RST from any state on the next edge and restarts the RST count. While held, the channel stays in RST.
- Sequenced release (SEQ_RELEASE=1):
  - rst_out_n[i] rises one cycle after rst_out_n[i-1] rises.
  - Loss on channel i-1 drops rst_out_n[i] one cycle later. Channel i's FSM stays in RUN.
- Timeout flags:
  - timeout[i] is sticky until timeout_clr=1 or rst_n=0.
  - If timeout_clr=1 and a new timeout occur in the same cycle, the set wins.
- ready_all is registered: the AND of rst_out_n, one cycle later.
- Lock from RST state is ignored; only WAIT qualifies lock.

Optional Feature:
- Macro: PLL_RELOCK_CNT_EN.
- Defined:
  - relock_cnt[8i+7:8i] increments on each RUN->RST transition caused by lock loss.
  - Transitions caused by pll_rst_req do not count.
  - The counter saturates at 255 and is cleared only by rst_n.
- Undefined: relock_cnt is tied to 0 and no counter logic is built.
- The port exists in both builds.

Test Plan (N_PLL=2, RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64):
- Clean lock: release rst_n, drive pll_lock[0]=1 steadily from the 10th cycle.
  - pll_rst[0] is high for exactly 4 cycles after reset release.
  - rst_out_n[0] rises exactly 10 cycles after pll_lock[0] rises.
  - ready_all stays 0 until channel 1 also locks.
- Glitch: pll_lock[0] high for 5 cycles, low for 1, then high.
  - Stable count restarts; rst_out_n[0] rises 10 cycles after the second rise.
- Timeout: hold pll_lock[1]=0.
  - After 64 WAIT cycles, timeout[1]=1 and pll_rst[1] pulses 4 cycles; this repeats every 68 cycles.
  - Pulse timeout_clr: timeout[1] returns to 0 until the next expiry.
- Loss in RUN: drop pll_lock[0] for 3 cycles.
  - rst_out_n[0] falls 3 cycles after the drop, followed by a 4-cycle pll_rst[0] pulse, then requalification.
  - With PLL_RELOCK_CNT_EN defined, relock_cnt[7:0]=1.
- SEQ_RELEASE=1, channel 1 locks 20 cycles before channel 0.
  - rst_out_n[1] stays 0 until rst_out_n[0]=1, then rises exactly 1 cycle later.
  - Dropping channel 0 lock drops rst_out_n[1] 1 cycle after rst_out_n[0] falls.
- Mid-operation reset: assert rst_n=0 with both channels in RUN and a soft request pending.
  - At the next edge all outputs take their reset values.
  - On release, both channels begin a fresh 4-cycle pll_rst pulse.
